// File: rtl/pong_pkg.sv
// Shared definitions for the pong input path: quadrature states, step
// directions and the Gray-code transition classifier.
package pong_pkg;

    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q10 = 2'b10;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q01 = 2'b01;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_ERR
    } dir_e;

    // Next state when channel A leads B (the "up" rotation).
    function automatic logic [1:0] quad_fwd(input logic [1:0] state);
        logic [1:0] nxt;
        case (state)
            Q00:     nxt = Q10;
            Q10:     nxt = Q11;
            Q11:     nxt = Q01;
            default: nxt = Q00;
        endcase
        return nxt;
    endfunction

    // Classifies one sampled transition {a,b}: prev -> cur.
    function automatic dir_e quad_dir(input logic [1:0] prev, input logic [1:0] cur);
        dir_e d;
        if (cur == prev) begin
            d = DIR_NONE;
        end else if ((cur ^ prev) == 2'b11) begin
            d = DIR_ERR;
        end else if (cur == quad_fwd(prev)) begin
            d = DIR_UP;
        end else begin
            d = DIR_DOWN;
        end
        return d;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Single-bit 2-FF synchroniser followed by a stability counter; the output
// follows the input only after it has held a new value long enough.
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 1200
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic dout_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("input_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter only runs while the synchronised value disagrees with the
    // accepted one, so any return to the old value restarts it from zero.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout_o = db_q;

endmodule

// File: rtl/paddle_encoder.sv
// Quadrature paddle front end: debounces both encoder channels, decodes the
// Gray-code stream into detent steps and keeps a saturating paddle position.
module paddle_encoder
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 1200,
    parameter int STEPS_PER_DETENT = 4,
    parameter int POS_WIDTH        = 5,
    parameter int POS_MAX          = 27,
    parameter int POS_RESET        = 13,
    parameter int INVERT           = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    output logic [POS_WIDTH-1:0] pos,
    output logic                 step_up,
    output logic                 step_down,
    output logic                 err,
    output logic                 ready
);

    localparam int SW          = $clog2(STEPS_PER_DETENT + 1) + 1;
    localparam int SETTLE_LAST = DEBOUNCE_CYCLES + 2;
    localparam int TW          = $clog2(SETTLE_LAST + 1);

    localparam logic signed [SW-1:0] SUB_ONE     = SW'(1);
    localparam logic signed [SW-1:0] SUB_UP_LAST = SW'(STEPS_PER_DETENT - 1);
    localparam logic signed [SW-1:0] SUB_DN_LAST = SW'(1 - STEPS_PER_DETENT);

    localparam logic [TW-1:0]        SETTLE_END = TW'(SETTLE_LAST);
    localparam logic [TW-1:0]        SETTLE_ONE = TW'(1);
    localparam logic [POS_WIDTH-1:0] POS_TOP    = POS_WIDTH'(POS_MAX);
    localparam logic [POS_WIDTH-1:0] POS_INIT   = POS_WIDTH'(POS_RESET);
    localparam logic [POS_WIDTH-1:0] POS_ONE    = POS_WIDTH'(1);

    if (POS_MAX >= (1 << POS_WIDTH)) begin : g_bad_pos_max
        $error("paddle_encoder: POS_MAX must be below 2**POS_WIDTH");
    end
    if (POS_RESET > POS_MAX || POS_RESET < 0) begin : g_bad_pos_reset
        $error("paddle_encoder: POS_RESET must lie within 0..POS_MAX");
    end
    if (STEPS_PER_DETENT < 1) begin : g_bad_steps
        $error("paddle_encoder: STEPS_PER_DETENT must be at least 1");
    end

    logic a_db;
    logic b_db;

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
        .clk    (clk),
        .reset  (reset),
        .din_i  (enc_a),
        .dout_o (a_db)
    );

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
        .clk    (clk),
        .reset  (reset),
        .din_i  (enc_b),
        .dout_o (b_db)
    );

    logic [1:0]           cur;
    logic [1:0]           prev_q,   prev_d;
    logic signed [SW-1:0] sub_q,    sub_d;
    logic [TW-1:0]        settle_q, settle_d;
    logic                 ready_q,  ready_d;
    logic [POS_WIDTH-1:0] pos_q,    pos_d;
    logic                 up_q,     up_d;
    logic                 dn_q,     dn_d;
    logic                 err_q,    err_d;
    logic                 raw_up;
    logic                 raw_dn;
    dir_e                 dir;

    assign cur = {a_db, b_db};
    assign dir = quad_dir(prev_q, cur);

    always_comb begin
        prev_d   = cur;
        sub_d    = sub_q;
        settle_d = settle_q;
        ready_d  = ready_q;
        pos_d    = pos_q;
        up_d     = 1'b0;
        dn_d     = 1'b0;
        err_d    = 1'b0;
        raw_up   = 1'b0;
        raw_dn   = 1'b0;

        // Until settled, prev just tracks the debounced inputs so whatever
        // the encoder rests at after reset is not mistaken for motion.
        if (!ready_q) begin
            if (settle_q == SETTLE_END) begin
                ready_d = 1'b1;
            end else begin
                settle_d = settle_q + SETTLE_ONE;
            end
        end else begin
            case (dir)
                DIR_UP: begin
                    if (sub_q == SUB_UP_LAST) begin
                        sub_d  = '0;
                        raw_up = 1'b1;
                    end else begin
                        sub_d = sub_q + SUB_ONE;
                    end
                end
                DIR_DOWN: begin
                    if (sub_q == SUB_DN_LAST) begin
                        sub_d  = '0;
                        raw_dn = 1'b1;
                    end else begin
                        sub_d = sub_q - SUB_ONE;
                    end
                end
                DIR_ERR: begin
                    sub_d = '0;
                    err_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (INVERT != 0) begin
            up_d = raw_dn;
            dn_d = raw_up;
        end else begin
            up_d = raw_up;
            dn_d = raw_dn;
        end

        // Steps still pulse at the end stops; only the position holds.
        if (up_d && pos_q != POS_TOP) begin
            pos_d = pos_q + POS_ONE;
        end else if (dn_d && pos_q != '0) begin
            pos_d = pos_q - POS_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q   <= Q00;
            sub_q    <= '0;
            settle_q <= '0;
            ready_q  <= 1'b0;
            pos_q    <= POS_INIT;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            sub_q    <= sub_d;
            settle_q <= settle_d;
            ready_q  <= ready_d;
            pos_q    <= pos_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            err_q    <= err_d;
        end
    end

    assign pos       = pos_q;
    assign step_up   = up_q;
    assign step_down = dn_q;
    assign err       = err_q;
    assign ready     = ready_q;

endmodule
